// File: rtl/ahb_lite_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ahb_lite_master: valid/ready command stream to pipelined AHB-Lite NONSEQ |
// | single transfers with in-order responses.              Revision: 1.0     |
// +--------------------------------------------------------------------------+
module ahb_lite_master #(
  parameter int AW = 12
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [1:0]    cmd_size,
  input  logic [31:0]   cmd_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic [2:0]    HSIZE,
  output logic          HWRITE,
  output logic [31:0]   HWDATA,
  input  logic          HREADY,
  input  logic [31:0]   HRDATA,
  input  logic          HRESP
);

  localparam logic [1:0] C_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] C_HTRANS_NONSEQ = 2'b10;

  logic          a_valid_q, a_valid_d;
  logic [AW-1:0] a_addr_q,  a_addr_d;
  logic [1:0]    a_size_q,  a_size_d;
  logic          a_write_q, a_write_d;
  logic [31:0]   a_wdata_q, a_wdata_d;
  logic          d_valid_q, d_valid_d;
  logic          d_write_q, d_write_d;
  logic [1:0]    d_size_q,  d_size_d;
  logic [1:0]    d_addr_q,  d_addr_d;
  logic          cancel_q,  cancel_d;
  logic [31:0]   hwdata_q,  hwdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q,   rsp_err_d;

  logic          w_advance;
  logic          w_err_first;
  logic          w_err_last;
  logic          w_accept;
  logic [1:0]    w_cmd_size;
  logic [AW-1:0] w_cmd_addr;
  logic [31:0]   w_rd_shift;
  logic [31:0]   w_rd_data;

  always_comb begin
    w_err_first = d_valid_q && HRESP && !HREADY;
    // Second ERROR cycle (or a cancelled pipeline draining): D retires, A holds.
    w_err_last  = HREADY && (cancel_q || (d_valid_q && HRESP));
    w_advance   = HREADY && !cancel_q && !(d_valid_q && HRESP);
    cmd_ready   = !cancel_q && (!a_valid_q || w_advance);
    w_accept    = cmd_valid && cmd_ready;

    w_cmd_size = (cmd_size == 2'd3) ? 2'd2 : cmd_size;
    w_cmd_addr = cmd_addr;
    if (w_cmd_size == 2'd1) w_cmd_addr[0] = 1'b0;
    if (w_cmd_size == 2'd2) w_cmd_addr[1:0] = 2'b00;

    w_rd_shift = HRDATA >> {d_addr_q, 3'b000};
    case (d_size_q)
      2'd0:    w_rd_data = {24'd0, w_rd_shift[7:0]};
      2'd1:    w_rd_data = d_addr_q[1] ? {16'd0, HRDATA[31:16]} : {16'd0, HRDATA[15:0]};
      default: w_rd_data = HRDATA;
    endcase
  end

  always_comb begin
    a_valid_d   = a_valid_q;
    a_addr_d    = a_addr_q;
    a_size_d    = a_size_q;
    a_write_d   = a_write_q;
    a_wdata_d   = a_wdata_q;
    d_valid_d   = d_valid_q;
    d_write_d   = d_write_q;
    d_size_d    = d_size_q;
    d_addr_d    = d_addr_q;
    cancel_d    = cancel_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    if (w_advance) begin
      d_valid_d = a_valid_q;
      d_write_d = a_write_q;
      d_size_d  = a_size_q;
      d_addr_d  = a_addr_q[1:0];
      a_valid_d = 1'b0;
      case (a_size_q)
        2'd0:    hwdata_d = {4{a_wdata_q[7:0]}};
        2'd1:    hwdata_d = {2{a_wdata_q[15:0]}};
        default: hwdata_d = a_wdata_q;
      endcase
    end else if (w_err_last) begin
      d_valid_d = 1'b0;
    end

    if (w_accept) begin
      a_valid_d = 1'b1;
      a_addr_d  = w_cmd_addr;
      a_size_d  = w_cmd_size;
      a_write_d = cmd_write;
      a_wdata_d = cmd_wdata;
    end

    if (w_err_first) begin
      cancel_d = 1'b1;
    end else if (cancel_q && HREADY) begin
      cancel_d = 1'b0;
    end

    if (HREADY && d_valid_q) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = HRESP;
      rsp_rdata_d = d_write_q ? 32'd0 : w_rd_data;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      a_valid_q   <= 1'b0;
      a_addr_q    <= '0;
      a_size_q    <= 2'd0;
      a_write_q   <= 1'b0;
      a_wdata_q   <= 32'd0;
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      d_size_q    <= 2'd0;
      d_addr_q    <= 2'd0;
      cancel_q    <= 1'b0;
      hwdata_q    <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_addr_q    <= a_addr_d;
      a_size_q    <= a_size_d;
      a_write_q   <= a_write_d;
      a_wdata_q   <= a_wdata_d;
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      d_size_q    <= d_size_d;
      d_addr_q    <= d_addr_d;
      cancel_q    <= cancel_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign HTRANS    = (a_valid_q && !cancel_q) ? C_HTRANS_NONSEQ : C_HTRANS_IDLE;
  assign HADDR     = a_addr_q;
  assign HSIZE     = {1'b0, a_size_q};
  assign HWRITE    = a_write_q;
  assign HWDATA    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ahb_lite_master: scoreboard bench with a behavioural memory slave.   |
// |                                                        Revision: 1.0     |
// +--------------------------------------------------------------------------+
module tb_ahb_lite_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [11:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

  ahb_lite_master #(.AW(12)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct { logic [31:0] rdata; logic err; logic [11:0] addr; } rsp_t;
  typedef struct { logic [11:0] addr; logic write; logic [2:0] size; } bus_t;

  rsp_t        sb[$];
  bus_t        bq[$];
  int          rsp_cyc[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [7:0]  rmem [0:4095];
  logic [7:0]  smem [0:4095];

  logic        ferr_en = 1'b0;
  logic [11:0] ferr_addr = 12'h000;
  logic        fwait_en = 1'b0;
  logic [11:0] fwait_addr = 12'h000;
  logic        rand_waits = 1'b0;
  logic        hang = 1'b0;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      rmem[i] = 8'h00;
      smem[i] = 8'h00;
    end
  end

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Slave rule shared by the reference and the slave model: addresses 0xC00+
  // (and one optionally forced address) always answer ERROR.
  function automatic logic is_err(input logic [11:0] a);
    return (a[11:10] == 2'b11) || (ferr_en && a == ferr_addr);
  endfunction

  function automatic logic [31:0] rdword(input logic [11:0] a);
    int b;
    b = int'({a[11:2], 2'b00});
    return {smem[b+3], smem[b+2], smem[b+1], smem[b]};
  endfunction

  // ---------------- behavioural AHB-Lite memory slave ----------------
  logic        dp_valid, dp_write, dp_err;
  logic [11:0] dp_addr;
  logic [1:0]  dp_size;
  int          dp_wait;

  always @(posedge HCLK or posedge HRESET) begin : slave
    int   w;
    int   lane;
    bus_t b;
    if (HRESET) begin
      HREADY <= 1'b1; HRESP <= 1'b0; HRDATA <= 32'd0;
      dp_valid <= 1'b0; dp_write <= 1'b0; dp_err <= 1'b0;
      dp_addr <= 12'd0; dp_size <= 2'd0; dp_wait <= 0;
    end else if (HREADY) begin
      if (dp_valid && dp_write && !dp_err) begin
        for (int i = 0; i < (1 << dp_size); i++) begin
          lane = (int'(dp_addr[1:0]) + i) % 4;
          smem[int'(dp_addr) + i] = HWDATA[8*lane +: 8];
        end
      end
      if (HTRANS == 2'b10) begin
        if (bq.size() == 0) begin
          chk("bus_unexpected_transfer", {20'd0, HADDR}, 32'hFFFFFFFF);
        end else begin
          b = bq.pop_front();
          chk("bus_haddr", {20'd0, HADDR}, {20'd0, b.addr});
          chk("bus_hwrite", {31'd0, HWRITE}, {31'd0, b.write});
          chk("bus_hsize", {29'd0, HSIZE}, {29'd0, b.size});
        end
        w = 0;
        if (fwait_en && HADDR == fwait_addr) w = 2;
        else if (rand_waits && $urandom_range(0, 2) == 0) w = $urandom_range(1, 3);
        dp_valid <= 1'b1; dp_write <= HWRITE; dp_addr <= HADDR;
        dp_size <= HSIZE[1:0]; dp_err <= is_err(HADDR); dp_wait <= w - 1;
        if (is_err(HADDR)) begin
          HREADY <= 1'b0; HRESP <= 1'b1; HRDATA <= 32'd0;
        end else if (hang || w > 0) begin
          HREADY <= 1'b0; HRESP <= 1'b0; HRDATA <= 32'd0;
        end else begin
          HREADY <= 1'b1; HRESP <= 1'b0; HRDATA <= rdword(HADDR);
        end
      end else begin
        dp_valid <= 1'b0; HREADY <= 1'b1; HRESP <= 1'b0;
      end
    end else begin
      if (dp_err) begin
        HREADY <= 1'b1; HRESP <= 1'b1;
      end else if (!hang) begin
        if (dp_wait <= 0) begin
          HREADY <= 1'b1; HRDATA <= rdword(dp_addr);
        end else begin
          dp_wait <= dp_wait - 1;
        end
      end
    end
  end

  // ---------------- response scoreboard monitor ----------------
  always @(negedge HCLK) begin : rsp_mon
    rsp_t e;
    if (!HRESET && rsp_valid) begin
      rsp_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("rsp_rdata@%h", e.addr), rsp_rdata, e.rdata);
        chk($sformatf("rsp_err@%h", e.addr), {31'd0, rsp_err}, {31'd0, e.err});
      end
    end
  end

  // ---------------- bus protocol monitor ----------------
  logic        p_stall;
  logic [11:0] p_addr;
  logic [2:0]  p_size;
  logic        p_write;

  always @(negedge HCLK) begin : bus_mon
    if (HRESET) begin
      p_stall <= 1'b0;
    end else begin
      chk("htrans_legal", {31'd0, (HTRANS == 2'b00 || HTRANS == 2'b10)}, 32'd1);
      if (p_stall) begin
        chk("stall_htrans", {30'd0, HTRANS}, 32'd2);
        chk("stall_haddr", {20'd0, HADDR}, {20'd0, p_addr});
        chk("stall_hsize", {29'd0, HSIZE}, {29'd0, p_size});
        chk("stall_hwrite", {31'd0, HWRITE}, {31'd0, p_write});
      end
      if (HREADY && HRESP) chk("err2_htrans_idle", {30'd0, HTRANS}, 32'd0);
      p_stall <= (HTRANS == 2'b10) && !HREADY && !HRESP;
      p_addr  <= HADDR;
      p_size  <= HSIZE;
      p_write <= HWRITE;
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic w, input logic [11:0] a, input logic [1:0] s,
                       input logic [31:0] d);
    rsp_t r;
    bus_t b;
    int   sz;
    logic acc;
    sz = (s == 2'd3) ? 2 : int'(s);
    r.addr = a; r.err = is_err(a); r.rdata = 32'd0;
    if (!r.err) begin
      for (int i = 0; i < (1 << sz); i++) begin
        if (w) rmem[int'(a) + i] = d[8*i +: 8];
        else   r.rdata = r.rdata | (32'(rmem[int'(a) + i]) << (8*i));
      end
    end
    sb.push_back(r);
    b.addr = a; b.write = w; b.size = 3'(sz);
    bq.push_back(b);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
    acc = 1'b0;
    for (int k = 0; k < 300; k++) begin
      acc = cmd_ready;
      @(posedge HCLK);
      if (acc) break;
      @(negedge HCLK);
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    @(negedge HCLK);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 500 && sb.size() > 0; k++) @(negedge HCLK);
    chk("drain_pending", sb.size(), 32'd0);
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic        w;
    logic [1:0]  s;
    logic [11:0] a;
    HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 12'd0;
    cmd_size = 2'd0; cmd_wdata = 32'd0;
    #1;
    chk("reset_htrans", {30'd0, HTRANS}, 32'd0);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);

    // Word write / read with cycle-accurate timing.
    issue(1'b1, 12'h010, 2'd2, 32'hDEADBEEF);
    chk("wr_nonseq_c1", {30'd0, HTRANS}, 32'd2);
    chk("wr_haddr_c1", {20'd0, HADDR}, 32'h010);
    chk("wr_hwrite_c1", {31'd0, HWRITE}, 32'd1);
    @(negedge HCLK);
    chk("wr_hwdata_c2", HWDATA, 32'hDEADBEEF);
    @(negedge HCLK);
    chk("wr_rsp_c3", {31'd0, rsp_valid}, 32'd1);
    drain();
    issue(1'b0, 12'h010, 2'd2, 32'd0);
    @(negedge HCLK);
    chk("rd_no_rsp_c2", {31'd0, rsp_valid}, 32'd0);
    @(negedge HCLK);
    chk("rd_rsp_c3", {31'd0, rsp_valid}, 32'd1);
    drain();

    // Byte write and lane checks.
    issue(1'b1, 12'h013, 2'd0, 32'h000000A5);
    chk("bw_hsize", {29'd0, HSIZE}, 32'd0);
    @(negedge HCLK);
    chk("bw_hwdata", HWDATA, 32'hA5A5A5A5);
    issue(1'b0, 12'h010, 2'd2, 32'd0);
    issue(1'b0, 12'h013, 2'd0, 32'd0);
    drain();

    // Four back-to-back reads, two wait states on the second.
    fwait_en = 1'b1; fwait_addr = 12'h004;
    rsp_cyc.delete();
    for (int i = 0; i < 4; i++) issue(1'b0, 12'(4*i), 2'd2, 32'd0);
    drain();
    fwait_en = 1'b0;
    chk("b2b_rsp_count", rsp_cyc.size(), 32'd4);
    if (rsp_cyc.size() == 4) begin
      chk("b2b_gap01", 32'(rsp_cyc[1] - rsp_cyc[0]), 32'd3);
      chk("b2b_gap12", 32'(rsp_cyc[2] - rsp_cyc[1]), 32'd1);
      chk("b2b_gap23", 32'(rsp_cyc[3] - rsp_cyc[2]), 32'd1);
    end

    // ERROR on the first of two pipelined writes.
    ferr_en = 1'b1; ferr_addr = 12'h020;
    issue(1'b1, 12'h020, 2'd2, 32'h11111111);
    issue(1'b1, 12'h024, 2'd2, 32'h22222222);
    drain();
    ferr_en = 1'b0;
    issue(1'b0, 12'h020, 2'd2, 32'd0);
    issue(1'b0, 12'h024, 2'd2, 32'd0);
    drain();

    // Halfword read and size 3.
    issue(1'b1, 12'h004, 2'd2, 32'h12345678);
    issue(1'b0, 12'h006, 2'd1, 32'd0);
    issue(1'b0, 12'h010, 2'd3, 32'd0);
    chk("size3_hsize", {29'd0, HSIZE}, 32'd2);
    drain();

    // Reset while a read is stalled.
    hang = 1'b1;
    issue(1'b0, 12'h030, 2'd2, 32'hFFFFFFFF);
    repeat (3) @(negedge HCLK);
    #2 HRESET = 1'b1;
    #1;
    chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
    chk("rst_haddr", {20'd0, HADDR}, 32'd0);
    chk("rst_hsize", {29'd0, HSIZE}, 32'd0);
    chk("rst_hwrite", {31'd0, HWRITE}, 32'd0);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_rsp", {rsp_valid, rsp_err, 30'd0}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    sb.delete();
    hang = 1'b0;
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
    repeat (3) @(negedge HCLK);
    issue(1'b0, 12'h010, 2'd2, 32'd0);
    drain();

    // Randomised traffic with random waits and an ERROR region.
    rand_waits = 1'b1;
    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      a = (($urandom_range(0, 7) == 0) ? 12'hC00 : 12'h100) + 12'($urandom_range(0, 31));
      if (s != 2'd0) a[0] = 1'b0;
      if (s[1]) a[1] = 1'b0;
      issue(w, a, s, $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge HCLK);
    end
    drain();
    rand_waits = 1'b0;
    chk("bus_queue_empty", bq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
